seg_monitor: RTL

Decoder-side companion to the stopwatch display driver. It samples the 8-bit seven-segment pattern that the counter drives onto `SEG` and turns it back into a digit. It also classifies every display change as up, down, zero-return or illegal jump, and measures the interval between changes. It sits on the same `clk_2` domain as the stopwatch and feeds `LED` and LCD debug fields, so the board can check its own display.

---
 rtl/seg_monitor.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/seg_monitor.sv
// Seven-segment readback monitor: debounces the sampled SEG pattern, decodes it to a digit,
// classifies display changes and times them. Define SEGMON_HEX_EN to decode 0x77 as 10.
`timescale 1ns/1ps
module seg_monitor #(
  parameter int unsigned NBITS_TOP     = 8,
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned NBITS_PERIOD  = 8,
  parameter int unsigned HOLD_CYCLES   = 4
) (
  input  logic                    clk_2,
  input  logic                    rst_n,
  input  logic [NBITS_TOP-1:0]    seg_in,
  output logic [3:0]              digit,
  output logic                    valid,
  output logic                    blank,
  output logic                    illegal,
  output logic                    evt_up,
  output logic                    evt_down,
  output logic                    evt_zero,
  output logic                    evt_jump,
  output logic [NBITS_PERIOD-1:0] period,
  output logic                    frozen
);

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StTrack = 2'd1;
  localparam logic [1:0] StBlank = 2'd2;
  localparam logic [1:0] StErr   = 2'd3;

  localparam logic [1:0] ClsNum   = 2'd0;
  localparam logic [1:0] ClsBlank = 2'd1;
  localparam logic [1:0] ClsIll   = 2'd2;

  localparam logic [3:0]              StableCnt = 4'(STABLE_CYCLES);
  localparam logic [NBITS_PERIOD-1:0] PeriodMax = '1;
  localparam logic [NBITS_PERIOD-1:0] PeriodOne = NBITS_PERIOD'(1);
  localparam logic [NBITS_PERIOD:0]   HoldCmp   = (NBITS_PERIOD+1)'(HOLD_CYCLES);

  logic [NBITS_TOP-1:0]    samp_q, samp_d, cand_q, cand_d, acc_q, acc_d;
  logic [3:0]              scnt_q, scnt_d;
  logic [1:0]              state_q, state_d;
  logic [3:0]              digit_q, digit_d;
  logic [NBITS_PERIOD-1:0] icnt_q, icnt_d, period_q, period_d, icnt_sat;
  logic [NBITS_PERIOD:0]   icnt_inc;
  logic                    up_q, up_d, down_q, down_d, zero_q, zero_d, jump_q, jump_d;
  logic                    frozen_q, frozen_d;
  logic                    accept, track_step;
  logic [3:0]              dec_val;
  logic [1:0]              dec_cls;

  // Decode the pattern that is about to become the candidate (cand_d is always samp_q).
  always_comb begin
    dec_val = 4'd0;
    dec_cls = ClsIll;
    case (samp_q)
      8'h3F: begin dec_val = 4'd0; dec_cls = ClsNum; end
      8'h06: begin dec_val = 4'd1; dec_cls = ClsNum; end
      8'h5B: begin dec_val = 4'd2; dec_cls = ClsNum; end
      8'h4F: begin dec_val = 4'd3; dec_cls = ClsNum; end
      8'h66: begin dec_val = 4'd4; dec_cls = ClsNum; end
      8'h6D: begin dec_val = 4'd5; dec_cls = ClsNum; end
      8'h7D: begin dec_val = 4'd6; dec_cls = ClsNum; end
      8'h07: begin dec_val = 4'd7; dec_cls = ClsNum; end
      8'h7F: begin dec_val = 4'd8; dec_cls = ClsNum; end
      8'h67: begin dec_val = 4'd9; dec_cls = ClsNum; end
`ifdef SEGMON_HEX_EN
      8'h77: begin dec_val = 4'd10; dec_cls = ClsNum; end
`else
      8'h77: dec_cls = ClsIll;
`endif
      8'h00: dec_cls = ClsBlank;
      default: dec_cls = ClsIll;
    endcase
  end

  always_comb begin
    samp_d = seg_in;
    cand_d = samp_q;
    if (samp_q != cand_q) begin
      scnt_d = 4'd1;
    end else begin
      scnt_d = (scnt_q == 4'd15) ? 4'd15 : scnt_q + 4'd1;
    end
    // Once accepted, acc matches cand, so a saturated count cannot re-fire.
    accept     = (scnt_d == StableCnt) && (samp_q != acc_q);
    track_step = accept && (state_q == StTrack) && (dec_cls == ClsNum);

    acc_d   = accept ? samp_q : acc_q;
    state_d = state_q;
    digit_d = digit_q;
    if (accept) begin
      case (dec_cls)
        ClsNum:   begin state_d = StTrack; digit_d = dec_val; end
        ClsBlank: state_d = StBlank;
        default:  state_d = StErr;
      endcase
    end

    up_d   = 1'b0;
    down_d = 1'b0;
    zero_d = 1'b0;
    jump_d = 1'b0;
    if (track_step) begin
      if (dec_val == digit_q + 4'd1) begin
        up_d = 1'b1;
      end else if ((digit_q != 4'd0) && (dec_val == digit_q - 4'd1)) begin
        down_d = 1'b1;
      end else if ((dec_val == 4'd0) && (digit_q > 4'd1)) begin
        zero_d = 1'b1;
      end else begin
        jump_d = 1'b1;
      end
    end

    icnt_sat = (icnt_q == PeriodMax) ? PeriodMax : icnt_q + PeriodOne;
    icnt_d   = accept ? '0 : icnt_sat;
    period_d = track_step ? icnt_sat : period_q;

    // Level form of "icnt+1 reached HOLD_CYCLES"; icnt only grows between acceptances.
    icnt_inc = {1'b0, icnt_d} + (NBITS_PERIOD+1)'(1);
    frozen_d = (state_d == StTrack) && (icnt_inc >= HoldCmp);
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      samp_q   <= '0;
      cand_q   <= '0;
      acc_q    <= '0;
      scnt_q   <= '0;
      state_q  <= StEmpty;
      digit_q  <= '0;
      icnt_q   <= '0;
      period_q <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      zero_q   <= 1'b0;
      jump_q   <= 1'b0;
      frozen_q <= 1'b0;
    end else begin
      samp_q   <= samp_d;
      cand_q   <= cand_d;
      acc_q    <= acc_d;
      scnt_q   <= scnt_d;
      state_q  <= state_d;
      digit_q  <= digit_d;
      icnt_q   <= icnt_d;
      period_q <= period_d;
      up_q     <= up_d;
      down_q   <= down_d;
      zero_q   <= zero_d;
      jump_q   <= jump_d;
      frozen_q <= frozen_d;
    end
  end

  assign digit    = digit_q;
  assign valid    = (state_q == StTrack);
  assign blank    = (state_q == StBlank);
  assign illegal  = (state_q == StErr);
  assign evt_up   = up_q;
  assign evt_down = down_q;
  assign evt_zero = zero_q;
  assign evt_jump = jump_q;
  assign period   = period_q;
  assign frozen   = frozen_q;

endmodule
